// File: rtl/vscale_pc_gen_if.sv
// Bundle between the pipeline control (master) and the PC generator (slave):
// stall/select/operand inputs plus the fetch PCs, misalignment report and RAS prediction.
interface vscale_pc_gen_if #(
  parameter int XLEN = 32
);
  logic            stall_IF;
  logic            stall_DX;
  logic [2:0]      PC_src_sel;
  logic [31:0]     inst_DX;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] handler_PC;
  logic [XLEN-1:0] epc;
  logic [XLEN-1:0] PC_PIF;
  logic [XLEN-1:0] PC_IF;
  logic [XLEN-1:0] PC_DX;
  logic            misaligned_fetch;
  logic [XLEN-1:0] bad_target;
  logic [XLEN-1:0] ras_top;
  logic            ras_valid;

  modport master (
    output stall_IF, stall_DX, PC_src_sel, inst_DX, rs1_data, handler_PC, epc,
    input  PC_PIF, PC_IF, PC_DX, misaligned_fetch, bad_target, ras_top, ras_valid
  );

  modport slave (
    input  stall_IF, stall_DX, PC_src_sel, inst_DX, rs1_data, handler_PC, epc,
    output PC_PIF, PC_IF, PC_DX, misaligned_fetch, bad_target, ras_top, ras_valid
  );
endinterface

// File: rtl/vscale_pc_gen.sv
// Next-PC generation, IF/DX PC registers, fetch-misalignment report and an optional
// return-address stack built only when VSCALE_PC_GEN_RAS_EN is defined.
module vscale_pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 'h200,
  parameter int              IALIGN    = 32,
  parameter int              RAS_DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  vscale_pc_gen_if.slave bus
);

  typedef enum logic [2:0] {
    SEL_PLUS4   = 3'd0,
    SEL_BRANCH  = 3'd1,
    SEL_JAL     = 3'd2,
    SEL_JALR    = 3'd3,
    SEL_REPLAY  = 3'd4,
    SEL_HANDLER = 3'd5,
    SEL_EPC     = 3'd6
  } pc_sel_e;

  logic [XLEN-1:0] pc_if_q, pc_dx_q;
  logic            misaligned_q;
  logic [XLEN-1:0] bad_target_q;

  logic [XLEN-1:0] b_imm, j_imm, i_imm, jalr_sum, target, pc_pif;
  logic            misaligned, trap_sel;
  logic            unused_opcode;

  assign b_imm    = {{(XLEN-12){bus.inst_DX[31]}}, bus.inst_DX[7], bus.inst_DX[30:25],
                     bus.inst_DX[11:8], 1'b0};
  assign j_imm    = {{(XLEN-20){bus.inst_DX[31]}}, bus.inst_DX[19:12], bus.inst_DX[20],
                     bus.inst_DX[30:21], 1'b0};
  assign i_imm    = {{(XLEN-11){bus.inst_DX[31]}}, bus.inst_DX[30:20]};
  assign jalr_sum = bus.rs1_data + i_imm;
  assign unused_opcode = ^bus.inst_DX[6:0];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    target = pc_if_q + XLEN'(4);
    case (bus.PC_src_sel)
      SEL_BRANCH:  target = pc_dx_q + b_imm;
      SEL_JAL:     target = pc_dx_q + j_imm;
      SEL_JALR:    target = {jalr_sum[XLEN-1:1], 1'b0};
      SEL_REPLAY:  target = pc_if_q;
      SEL_HANDLER: target = bus.handler_PC;
      SEL_EPC:     target = bus.epc;
      default:     ;
    endcase
  end

  // Bit 1 only matters when compressed instructions are not allowed.
  assign misaligned = target[0] | ((IALIGN == 32) && target[1]);
  assign pc_pif     = misaligned ? pc_if_q : target;
  assign trap_sel   = (bus.PC_src_sel == SEL_HANDLER) || (bus.PC_src_sel == SEL_EPC);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_if_q      <= RESET_PC;
      pc_dx_q      <= RESET_PC;
      misaligned_q <= 1'b0;
      bad_target_q <= '0;
    end else begin
      if (!bus.stall_IF || trap_sel) pc_if_q <= pc_pif;
      if (!bus.stall_DX)             pc_dx_q <= pc_if_q;
      misaligned_q <= misaligned;
      if (misaligned) bad_target_q <= target;
    end
  end

  assign bus.PC_PIF           = pc_pif;
  assign bus.PC_IF            = pc_if_q;
  assign bus.PC_DX            = pc_dx_q;
  assign bus.misaligned_fetch = misaligned_q;
  assign bus.bad_target       = bad_target_q;

`ifdef VSCALE_PC_GEN_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [CNT_W-1:0] ras_cnt;
  logic [4:0]       rd, rs1;
  logic             rd_link, rs1_link, is_jal, is_jalr, push, pop, ras_empty;
  logic [XLEN-1:0]  link_addr;

  assign rd        = bus.inst_DX[11:7];
  assign rs1       = bus.inst_DX[19:15];
  assign rd_link   = (rd == 5'd1) || (rd == 5'd5);
  assign rs1_link  = (rs1 == 5'd1) || (rs1 == 5'd5);
  assign is_jal    = (bus.PC_src_sel == SEL_JAL);
  assign is_jalr   = (bus.PC_src_sel == SEL_JALR);
  assign push      = !misaligned && (is_jal || is_jalr) && rd_link;
  assign pop       = !misaligned && is_jalr && rs1_link && (!rd_link || (rd != rs1));
  assign ras_empty = (ras_cnt == '0);
  assign link_addr = pc_dx_q + XLEN'(4);

  // NOTE: the entry array has no reset; ras_valid masks stale contents, so only pointer and count reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (trap_sel) begin
      ras_cnt <= '0;
    end else if (push && pop && !ras_empty) begin
      ras_mem[ras_ptr] <= link_addr;
    end else if (push) begin
      ras_mem[ras_ptr + PTR_W'(1)] <= link_addr;
      ras_ptr <= ras_ptr + PTR_W'(1);
      if (ras_cnt != CNT_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + CNT_W'(1);
    end else if (pop && !ras_empty) begin
      ras_ptr <= ras_ptr - PTR_W'(1);
      ras_cnt <= ras_cnt - CNT_W'(1);
    end
  end

  assign bus.ras_valid = !ras_empty;
  assign bus.ras_top   = ras_mem[ras_ptr];
`else
  assign bus.ras_valid = 1'b0;
  assign bus.ras_top   = '0;
`endif

endmodule

// File: tb/tb_vscale_pc_gen.sv
// Directed bench for vscale_pc_gen: one IALIGN=32 and one IALIGN=16 instance share stimulus;
// RAS expectations follow VSCALE_PC_GEN_RAS_EN.
module tb_vscale_pc_gen;
  localparam logic [31:0] RST_PC = 32'h200;
  localparam logic [2:0] PLUS4 = 3'd0, BRANCH = 3'd1, JAL = 3'd2, JALR = 3'd3,
                         REPLAY = 3'd4, HANDLER = 3'd5, EPC = 3'd6, SEL7 = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_if, stall_dx;
  logic [2:0]  sel;
  logic [31:0] inst, rs1_data, handler_pc, epc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vscale_pc_gen_if #(.XLEN(32)) bus ();
  vscale_pc_gen_if #(.XLEN(32)) bus16 ();

  assign bus.stall_IF     = stall_if;
  assign bus.stall_DX     = stall_dx;
  assign bus.PC_src_sel   = sel;
  assign bus.inst_DX      = inst;
  assign bus.rs1_data     = rs1_data;
  assign bus.handler_PC   = handler_pc;
  assign bus.epc          = epc;
  assign bus16.stall_IF   = stall_if;
  assign bus16.stall_DX   = stall_dx;
  assign bus16.PC_src_sel = sel;
  assign bus16.inst_DX    = inst;
  assign bus16.rs1_data   = rs1_data;
  assign bus16.handler_PC = handler_pc;
  assign bus16.epc        = epc;

  vscale_pc_gen #(.XLEN(32), .RESET_PC(RST_PC), .IALIGN(32), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  vscale_pc_gen #(.XLEN(32), .RESET_PC(RST_PC), .IALIGN(16), .RAS_DEPTH(4)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_ras(input string tag, input logic valid, input logic [31:0] top);
`ifdef VSCALE_PC_GEN_RAS_EN
    check({tag, "_valid"}, {63'd0, bus.ras_valid}, {63'd0, valid});
    if (valid) check({tag, "_top"}, {32'd0, bus.ras_top}, {32'd0, top});
`else
    check({tag, "_valid"}, {63'd0, bus.ras_valid}, 64'd0);
    check({tag, "_top"}, {32'd0, bus.ras_top}, 64'd0);
`endif
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int rd);
    logic [11:0] i;
    i = imm[11:0];
    return {i, rs1[4:0], 3'b000, rd[4:0], 7'h67};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [20:0] j;
    j = imm[20:0];
    return {j[20], j[10:1], j[11], j[19:12], rd[4:0], 7'h6F};
  endfunction

  function automatic logic [31:0] enc_b(input int imm);
    logic [12:0] b;
    b = imm[12:0];
    return {b[12], b[10:5], 5'd0, 5'd0, 3'd0, b[4:1], b[11], 7'h63};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Jump PC_IF to x via JALR with rd=x0 (no RAS effect).
  task automatic set_pc(input logic [31:0] x);
    sel = JALR; inst = enc_i(0, 2, 0); rs1_data = x; stall_if = 1'b0; stall_dx = 1'b1;
    step();
  endtask

  task automatic set_dx(input logic [31:0] x);
    set_pc(x);
    sel = PLUS4; stall_if = 1'b1; stall_dx = 1'b0;
    step();
    stall_dx = 1'b1;
  endtask

  logic [31:0] pop_tops [3] = '{32'h404, 32'h304, 32'h204};

  initial begin
    reset = 1'b1; stall_if = 1'b0; stall_dx = 1'b0; sel = PLUS4;
    inst = 32'd0; rs1_data = 32'd0; handler_pc = 32'd0; epc = 32'd0;
    step(); step();

    check("rst_pc_if", bus.PC_IF, 32'h200);
    check("rst_pc_dx", bus.PC_DX, 32'h200);
    check("rst_misaligned", bus.misaligned_fetch, 1'b0);
    check("rst_bad_target", bus.bad_target, 32'h0);
    expect_ras("rst_ras", 1'b0, 32'h0);

    reset = 1'b0;
    settle();
    check("plus4_pif", bus.PC_PIF, 32'h204);
    step(); check("plus4_1", bus.PC_IF, 32'h204);
    step(); check("plus4_2", bus.PC_IF, 32'h208);
    step(); check("plus4_3", bus.PC_IF, 32'h20C);
    check("plus4_dx", bus.PC_DX, 32'h208);

    set_dx(32'h300);
    check("setdx_dx", bus.PC_DX, 32'h300);
    check("setdx_if_held", bus.PC_IF, 32'h300);
    sel = JAL; inst = enc_j(32'h20, 1); stall_if = 1'b0;
    settle();
    check("jal_pif", bus.PC_PIF, 32'h320);
    step();
    check("jal_pc_if", bus.PC_IF, 32'h320);
    expect_ras("jal_push", 1'b1, 32'h304);

    sel = BRANCH; inst = enc_b(32'h500); stall_if = 1'b1;
    settle();
    check("branch_pif", bus.PC_PIF, 32'h800);
    step();
    check("stall_hold", bus.PC_IF, 32'h320);
    sel = HANDLER; handler_pc = 32'h100;
    step();
    check("handler_pc_if", bus.PC_IF, 32'h100);
    expect_ras("handler_clear", 1'b0, 32'h0);
    sel = EPC; epc = 32'h654;
    step();
    check("epc_pc_if", bus.PC_IF, 32'h654);
    sel = REPLAY; stall_if = 1'b0;
    settle();
    check("replay_pif", bus.PC_PIF, 32'h654);
    step();
    check("replay_pc_if", bus.PC_IF, 32'h654);
    sel = SEL7;
    settle();
    check("sel7_pif", bus.PC_PIF, 32'h658);
    sel = JALR; inst = enc_i(0, 2, 0); rs1_data = 32'h401;
    settle();
    check("jalr_bit0_pif", bus.PC_PIF, 32'h400);
    step();
    check("jalr_bit0_mis", bus.misaligned_fetch, 1'b0);

    set_dx(32'h1000);
    sel = JAL; inst = enc_j(-16, 0);
    settle();
    check("jal_neg_pif", bus.PC_PIF, 32'hFF0);
    sel = BRANCH; inst = enc_b(-6);
    settle();
    check("br_mis_pif32", bus.PC_PIF, 32'h1000);
    check("br_mis_pif16", bus16.PC_PIF, 32'hFFA);
    step();
    check("br_mis_flag", bus.misaligned_fetch, 1'b1);
    check("br_mis_target", bus.bad_target, 32'hFFA);

    reset = 1'b1; step(); reset = 1'b0;
    sel = JALR; inst = enc_i(0, 2, 1); rs1_data = 32'h402; stall_if = 1'b0; stall_dx = 1'b0;
    settle();
    check("jalr_mis_pif32", bus.PC_PIF, 32'h200);
    check("jalr_mis_pif16", bus16.PC_PIF, 32'h402);
    step();
    check("jalr_mis_flag", bus.misaligned_fetch, 1'b1);
    check("jalr_mis_target", bus.bad_target, 32'h402);
    check("jalr_mis_pc_if", bus.PC_IF, 32'h200);
    check("jalr16_no_flag", bus16.misaligned_fetch, 1'b0);
    expect_ras("jalr_mis_nopush", 1'b0, 32'h0);
    sel = PLUS4;
    step();
    check("mis_one_cycle", bus.misaligned_fetch, 1'b0);
    check("mis_target_hold", bus.bad_target, 32'h402);

    reset = 1'b1; step(); reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      set_dx(32'(k * 32'h100));
      sel = JAL; inst = enc_j(8, 1); stall_if = 1'b1;
      step();
    end
    expect_ras("push5", 1'b1, 32'h504);
    sel = JALR; inst = enc_i(0, 1, 0); rs1_data = 32'h1000; stall_if = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_ras($sformatf("pop%0d", i + 1), 1'b1, pop_tops[i]);
    end
    step();
    expect_ras("pop4", 1'b0, 32'h0);
    step();
    expect_ras("pop5_empty", 1'b0, 32'h0);
`ifdef VSCALE_PC_GEN_RAS_EN
    check("pop5_top_kept", bus.ras_top, 32'h504);
`endif

    set_dx(32'h700);
    sel = JAL; inst = enc_j(8, 1);
    step();
    expect_ras("pp_push", 1'b1, 32'h704);
    set_dx(32'h800);
    sel = JALR; inst = enc_i(0, 1, 5); rs1_data = 32'h1000;
    step();
    expect_ras("pop_push", 1'b1, 32'h804);
    sel = JALR; inst = enc_i(0, 1, 0);
    step();
    expect_ras("pop_push_cnt", 1'b0, 32'h0);

    sel = JAL; inst = enc_j(8, 1); stall_if = 1'b1;
    step();
    expect_ras("pre_rst_push", 1'b1, 32'h804);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_push_pc_if", bus.PC_IF, 32'h200);
    check("rst_push_pc_dx", bus.PC_DX, 32'h200);
    expect_ras("rst_push_ras", 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/vscale_pc_gen.md
VSCALE_PC_GEN -- requirements
Module: vscale_pc_gen

Interface
REQ-001 Parameter XLEN, default 32: datapath and PC width; legal values 32, 64.
REQ-002 Parameter RESET_PC, default 'h200: PC_IF value after reset.
REQ-003 Parameter IALIGN, default 32: instruction alignment in bits; legal values 32, 16.
REQ-004 Parameter RAS_DEPTH, default 4: return-address-stack entries; power of two, 2..16.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 stall_IF  input  1  hold PC_IF.
REQ-008 stall_DX  input  1  hold PC_DX.
REQ-009 PC_src_sel  input  3  0 PLUS4, 1 BRANCH, 2 JAL, 3 JALR, 4 REPLAY, 5 HANDLER, 6 EPC; 7 treated as PLUS4.
REQ-010 inst_DX  input  32  instruction in DX stage.
REQ-011 rs1_data  input  XLEN  JALR base operand.
REQ-012 handler_PC, epc  input  XLEN each  trap vector and exception return address.
REQ-013 PC_PIF  output  XLEN  combinational next fetch address.
REQ-014 PC_IF, PC_DX  output  XLEN each  registered fetch-stage and decode/execute-stage PCs.
REQ-015 misaligned_fetch  output  1  registered; target violated IALIGN.
REQ-016 bad_target  output  XLEN  registered misaligned target address.
REQ-017 ras_top, ras_valid  output  XLEN, 1  predicted return address and its validity.

Function
REQ-018 Target SHALL be base+offset modulo 2^XLEN: PLUS4 PC_IF+4; BRANCH PC_DX+B-imm; JAL PC_DX+J-imm; JALR (rs1_data+I-imm) with bit0 cleared; REPLAY PC_IF; HANDLER handler_PC; EPC epc; immediates sign-extended to XLEN.
REQ-019 Target is misaligned when bit1 set (IALIGN=32 only) or bit0 set; bit0 never set for JALR.
REQ-020 PC_PIF SHALL equal target when aligned, else PC_IF.
REQ-021 When stall_IF=0, PC_IF SHALL load PC_PIF next cycle; when stall_IF=1, PC_IF holds, except HANDLER and EPC, which always load.
REQ-022 When stall_DX=0, PC_DX SHALL load PC_IF; else hold.
REQ-023 misaligned_fetch SHALL assert for exactly one cycle after a misaligned target; bad_target SHALL capture that target in the same cycle and hold until the next misaligned event.
REQ-024 Link register = x1 or x5; push = JAL/JALR with rd link; pop = JALR with rs1 link and rd not link; both only when PC_src_sel selects JAL/JALR and target aligned.
REQ-025 Push SHALL write PC_DX+4 at pointer+1 and advance pointer; count saturates at RAS_DEPTH, oldest entry overwritten (wrap-around).
REQ-026 Pop SHALL decrement pointer and count; pop on empty SHALL leave state unchanged.
REQ-027 JALR with rd and rs1 both link, rd != rs1: pop then push (top replaced, count unchanged); rd == rs1: push only.
REQ-028 HANDLER or EPC select SHALL clear RAS count in the same cycle, overriding push/pop.
REQ-029 ras_valid = (count != 0); ras_top = entry at pointer; both registered-state-derived, no combinational path from inputs.

Reset
REQ-030 reset SHALL set PC_IF=RESET_PC, PC_DX=RESET_PC, misaligned_fetch=0, bad_target=0, RAS pointer=0, count=0, ras_valid=0; RAS entry contents need not be cleared.
REQ-031 reset SHALL override all other inputs the same cycle, including mid-push and during stall.

Configuration
REQ-032 Macro VSCALE_PC_GEN_RAS_EN: when defined, RAS per REQ-024..029 is built; when undefined, no RAS storage exists, ras_valid is constant 0, ras_top constant 0, all other behaviour identical.

Verification
REQ-033 Reset then 3 cycles PLUS4, no stall -> PC_IF 'h200, 'h204, 'h208, 'h20C.
REQ-034 PC_DX='h300, JAL imm +'h20, rd=x1 -> PC_PIF='h320; with RAS_EN, next cycle ras_valid=1, ras_top='h304.
REQ-035 IALIGN=32, JALR rs1_data='h402, imm 0 -> PC_PIF=PC_IF, next cycle misaligned_fetch=1 for one cycle, bad_target='h402, no RAS push; IALIGN=16 same stimulus -> PC_PIF='h402.
REQ-036 RAS_DEPTH=4, five pushes of 'h104..'h504 then five pops -> ras_top 'h504,'h404,'h304,'h204, then ras_valid=0; fifth pop leaves state unchanged.
REQ-037 stall_IF=1 with BRANCH target 'h800 -> PC_IF holds; same cycle HANDLER handler_PC='h100 -> PC_IF='h100, ras_valid=0.
REQ-038 Push issued with reset=1 same cycle -> PC_IF=RESET_PC, ras_valid=0.
